player_sprite_render: RTL and testbench
=======================================

Name: player_sprite_render

Overview:
- Consumer end of the player movement interface: takes per-frame position, facing and motion flags and turns them into per-pixel sprite colour for the VGA compositor.
- Latches player state once per frame at frame_start. Runs the animation state machine. Generates mirrored sprite-ROM addresses and outputs keyed pixels through a fixed 2-stage pipeline.
- One instance per player. Sits between player_move and the pixel mixer.

Parameters:
- POS_WIDTH, 10, width of pos_x/pos_y/hcount/vcount
- SPR_W, 32, sprite width in pixels (power of 2)
- SPR_H, 64, sprite height in pixels (power of 2)
- NUM_FRAMES, 8, animation frames in ROM (power of 2)
- ANIM_DIV, 6, frame_start pulses per walk-animation step
- COLOR_W, 8, pixel colour width
- KEY_COLOR, 8'hE3, transparent colour in ROM data
- ROM_AW, log2(NUM_FRAMES)+log2(SPR_H)+log2(SPR_W) = 14, ROM address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- pix_en  in  1  pixel-rate enable; all pipeline and pixel logic advances only when high
- frame_start  in  1  one-clk pulse at the start of vertical blank
- hcount  in  POS_WIDTH  current pixel column
- vcount  in  POS_WIDTH  current pixel row
- video_on  in  1  active display region
- pos_x  in  POS_WIDTH  sprite left edge
- pos_y  in  POS_WIDTH  sprite top edge
- facing_right  in  1  sprite faces +x (unmirrored) when 1
- move_active  in  1  player moving this frame
- jump_active  in  1  player airborne
- rom_addr  out  ROM_AW  sprite ROM address, {frame, row, col}
- rom_data  in  COLOR_W  ROM data, valid one pix_en cycle after rom_addr
- pix_valid  out  1  sprite covers this pixel and the colour is not the key
- pix_color  out  COLOR_W  sprite colour when pix_valid, else 0
- anim_frame  out  log2(NUM_FRAMES)  current animation frame (debug/HUD)

Behaviour:
- Reset: rom_addr=0, pix_valid=0, pix_color=0, anim_frame=0. Shadow x/y=0, shadow facing=1, anim state IDLE, divider=0, pipeline valid bits=0. Reset mid-line clears the pipeline immediately; no stale pixel is emitted.
- Frame latch: on frame_start, shadow_x, shadow_y, shadow_facing, shadow_move and shadow_jump all load from the inputs. Inputs are ignored at all other times, so the sprite never tears mid-frame. frame_start acts regardless of pix_en.
- Animation FSM: evaluated on frame_start, using the freshly sampled inputs.
  - IDLE: anim_frame=0.
  - WALK: frames cycle 0,1,2,3,0… Advance one step each time the divider reaches ANIM_DIV-1; the divider then wraps to 0.
  - JUMP: anim_frame=4, held.
  - Transitions: jump_active goes to JUMP from any state. From JUMP, !jump_active returns to WALK if move_active, else IDLE. Otherwise move_active goes to WALK and !move_active goes to IDLE.
  - Entering WALK from any other state sets anim_frame=0 and divider=0.
  - jump_active has priority over move_active.
- Stage 0 (pix_en):
  - dx = hcount - shadow_x and dy = vcount - shadow_y, computed at POS_WIDTH+1 bits so a negative result is detected.
  - hit = video_on && 0<=dx<SPR_W && 0<=dy<SPR_H.
  - col = shadow_facing ? dx[lsbs] : SPR_W-1-dx[lsbs].
  - rom_addr <= {anim_frame, dy[lsbs], col}; hit_d1 <= hit.
  - When hit=0, rom_addr holds its previous value.
- Stage 1 (pix_en): pix_valid <= hit_d1 && rom_data != KEY_COLOR; pix_color <= pix_valid-term ? rom_data : 0.
- Latency: from hcount/vcount to pix_valid/pix_color is exactly 2 pix_en cycles. The compositor delays its own counters by 2 to match.
- pix_en low: all pipeline registers hold.
- Edge clipping: a sprite extending past the right or bottom edge simply stops at video_on=0. shadow_x > H-active gives no hits. No wrap-around: hcount < shadow_x is never a hit, including shadow_x near 2^POS_WIDTH-1.
- frame_start coincident with pix_en: the latch and the pipeline step both occur. The new shadow values apply from the next cycle.

Test Plan:
- Reset release, pos_x=100, pos_y=200, facing_right=1, idle: frame_start, then scan hcount 99..132 at vcount=200 -> pix_valid rises exactly 2 pix_en cycles after hcount=100, rom_addr col=0..31, no hit at hcount 99 or 132.
- facing_right=0, same position -> at hcount=100 rom_addr col=31, at hcount=131 col=0; anim_frame=0.
- move_active=1 across 30 frame_starts, ANIM_DIV=6 -> anim_frame sequence 0,1,2,3,0 changing every 6 frames. Then jump_active=1 -> anim_frame=4 at the next frame_start. Jump ends with move_active=1 -> WALK at frame 0.
- rom_data=KEY_COLOR within the sprite box -> pix_valid=0 and pix_color=0. rom_data=8'h1C -> pix_valid=1, pix_color=8'h1C.
- pos_x changed to 300 mid-frame, no frame_start -> hits remain at x=100 until the next frame_start, then move to x=300.
- pos_x=1020 (near wrap), hcount 0..10 -> no hits. Assert reset mid-sprite -> pix_valid=0 on the same cycle, all outputs at reset values.

Source files
------------

// File: rtl/player_sprite_render.sv
// Per-player sprite renderer: latches player state at frame_start, runs the walk/jump
// animation, and emits keyed sprite pixels through a fixed two-stage pix_en pipeline.
module player_sprite_render #(
  parameter int POS_WIDTH  = 10,
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 64,
  parameter int NUM_FRAMES = 8,
  parameter int ANIM_DIV   = 6,
  parameter int COLOR_W    = 8,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 8'hE3,
  parameter int ROM_AW     = $clog2(NUM_FRAMES) + $clog2(SPR_H) + $clog2(SPR_W)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pix_en,
  input  logic                          frame_start,
  input  logic [POS_WIDTH-1:0]          hcount,
  input  logic [POS_WIDTH-1:0]          vcount,
  input  logic                          video_on,
  input  logic [POS_WIDTH-1:0]          pos_x,
  input  logic [POS_WIDTH-1:0]          pos_y,
  input  logic                          facing_right,
  input  logic                          move_active,
  input  logic                          jump_active,
  output logic [ROM_AW-1:0]             rom_addr,
  input  logic [COLOR_W-1:0]            rom_data,
  output logic                          pix_valid,
  output logic [COLOR_W-1:0]            pix_color,
  output logic [$clog2(NUM_FRAMES)-1:0] anim_frame
);

  localparam int FR_W  = $clog2(NUM_FRAMES);
  localparam int ROW_W = $clog2(SPR_H);
  localparam int COL_W = $clog2(SPR_W);
  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_JUMP} anim_state_e;

  anim_state_e            state_q, state_d;
  logic [FR_W-1:0]        anim_frame_q, anim_frame_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [POS_WIDTH-1:0]   shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
  logic                   shadow_facing_q, shadow_facing_d;
  logic                   shadow_move_q, shadow_move_d, shadow_jump_q, shadow_jump_d;
  logic [ROM_AW-1:0]      rom_addr_q, rom_addr_d;
  logic                   hit_d1_q, hit_d1_d;
  logic                   pix_valid_q, pix_valid_d;
  logic [COLOR_W-1:0]     pix_color_q, pix_color_d;

  logic [POS_WIDTH:0]     dx, dy;
  logic                   hit, opaque;
  logic [COL_W-1:0]       col;
  logic [FR_W-1:0]        walk_next;

  // Frame latch and animation: everything here only moves on frame_start.
  always_comb begin
    shadow_x_d      = shadow_x_q;
    shadow_y_d      = shadow_y_q;
    shadow_facing_d = shadow_facing_q;
    shadow_move_d   = shadow_move_q;
    shadow_jump_d   = shadow_jump_q;
    state_d         = state_q;
    anim_frame_d    = anim_frame_q;
    div_d           = div_q;
    walk_next       = (anim_frame_q == FR_W'(3)) ? '0 : anim_frame_q + FR_W'(1);
    if (frame_start) begin
      shadow_x_d      = pos_x;
      shadow_y_d      = pos_y;
      shadow_facing_d = facing_right;
      shadow_move_d   = move_active;
      shadow_jump_d   = jump_active;
      if (jump_active)      state_d = S_JUMP;
      else if (move_active) state_d = S_WALK;
      else                  state_d = S_IDLE;
      case (state_d)
        S_JUMP: begin
          anim_frame_d = FR_W'(4);
          div_d        = '0;
        end
        S_WALK: begin
          if (state_q != S_WALK) begin
            anim_frame_d = '0;
            div_d        = '0;
          end else if (div_q == DIV_W'(ANIM_DIV - 1)) begin
            anim_frame_d = walk_next;
            div_d        = '0;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: begin
          anim_frame_d = '0;
          div_d        = '0;
        end
      endcase
    end
  end

  // One extra sign bit keeps hcount < shadow_x from wrapping into a hit.
  always_comb begin
    dx     = {1'b0, hcount} - {1'b0, shadow_x_q};
    dy     = {1'b0, vcount} - {1'b0, shadow_y_q};
    hit    = video_on && (dx[POS_WIDTH:COL_W] == '0) && (dy[POS_WIDTH:ROW_W] == '0);
    col    = shadow_facing_q ? dx[COL_W-1:0] : COL_W'(SPR_W - 1) - dx[COL_W-1:0];
    opaque = hit_d1_q && (rom_data != KEY_COLOR);

    rom_addr_d  = rom_addr_q;
    hit_d1_d    = hit_d1_q;
    pix_valid_d = pix_valid_q;
    pix_color_d = pix_color_q;
    if (pix_en) begin
      if (hit) rom_addr_d = {anim_frame_q, dy[ROW_W-1:0], col};
      hit_d1_d    = hit;
      pix_valid_d = opaque;
      pix_color_d = opaque ? rom_data : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      anim_frame_q    <= '0;
      div_q           <= '0;
      shadow_x_q      <= '0;
      shadow_y_q      <= '0;
      shadow_facing_q <= 1'b1;
      shadow_move_q   <= 1'b0;
      shadow_jump_q   <= 1'b0;
      rom_addr_q      <= '0;
      hit_d1_q        <= 1'b0;
      pix_valid_q     <= 1'b0;
      pix_color_q     <= '0;
    end else begin
      state_q         <= state_d;
      anim_frame_q    <= anim_frame_d;
      div_q           <= div_d;
      shadow_x_q      <= shadow_x_d;
      shadow_y_q      <= shadow_y_d;
      shadow_facing_q <= shadow_facing_d;
      shadow_move_q   <= shadow_move_d;
      shadow_jump_q   <= shadow_jump_d;
      rom_addr_q      <= rom_addr_d;
      hit_d1_q        <= hit_d1_d;
      pix_valid_q     <= pix_valid_d;
      pix_color_q     <= pix_color_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign pix_valid  = pix_valid_q;
  assign pix_color  = pix_color_q;
  assign anim_frame = anim_frame_q;

endmodule

// File: tb/tb_player_sprite_render.sv
// Directed bench for player_sprite_render: a combinational ROM model returns the
// column index as colour, so every expected pixel is derived from position alone.
module tb_player_sprite_render;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b1;
  logic        frame_start = 1'b0;
  logic [9:0]  hcount = '0, vcount = '0, pos_x = '0, pos_y = '0;
  logic        video_on = 1'b0, facing_right = 1'b1, move_active = 1'b0, jump_active = 1'b0;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data, pix_color;
  logic        pix_valid;
  logic [2:0]  anim_frame;
  logic        rom_force = 1'b0;
  logic [7:0]  rom_force_val = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  player_sprite_render dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .frame_start(frame_start),
    .hcount(hcount), .vcount(vcount), .video_on(video_on),
    .pos_x(pos_x), .pos_y(pos_y), .facing_right(facing_right),
    .move_active(move_active), .jump_active(jump_active),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_color(pix_color), .anim_frame(anim_frame)
  );

  always #5 clk = ~clk;

  assign rom_data = rom_force ? rom_force_val : {3'b000, rom_addr[4:0]};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_frame(input logic [9:0] x, input logic [9:0] y, input logic face,
                             input logic mv, input logic jp);
    pos_x = x; pos_y = y; facing_right = face; move_active = mv; jump_active = jp;
    video_on = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Holds one pixel steady long enough for both pipeline stages to settle.
  task automatic point(input string name, input int h, input int v, input logic von,
                       input logic exp_valid, input logic [7:0] exp_color);
    hcount = 10'(h); vcount = 10'(v); video_on = von;
    tick(); tick();
    n_vec++;
    if (pix_valid !== exp_valid || pix_color !== exp_color) begin
      n_err++;
      $display("FAIL %s: got valid=%0b color=%0h, expected valid=%0b color=%0h",
               name, pix_valid, pix_color, exp_valid, exp_color);
    end
  endtask

  // Scans a run of columns on one row, checking rom_addr per cycle and the pixel
  // output that belongs to the previous column.
  task automatic scan(input string name, input int h_lo, input int h_hi, input int v,
                      input int x0, input int y0, input logic face, input logic [2:0] fr);
    logic        prev_hit = 1'b0, have_prev = 1'b0, have_addr = 1'b0, hit;
    logic [7:0]  prev_color = '0;
    logic [4:0]  col;
    logic [13:0] exp_addr = '0;
    for (int h = h_lo; h <= h_hi; h++) begin
      hcount = 10'(h); vcount = 10'(v); video_on = 1'b1;
      tick();
      hit = (h >= x0) && (h - x0 < 32) && (v >= y0) && (v - y0 < 64);
      col = face ? 5'(h - x0) : 5'(31 - (h - x0));
      if (hit) begin
        exp_addr  = {fr, 6'(v - y0), col};
        have_addr = 1'b1;
      end
      if (have_addr) begin
        n_vec++;
        if (rom_addr !== exp_addr) begin
          n_err++;
          $display("FAIL %s rom_addr h=%0d: got %0h, expected %0h", name, h, rom_addr, exp_addr);
        end
      end
      if (have_prev) begin
        n_vec++;
        if (pix_valid !== prev_hit || pix_color !== (prev_hit ? prev_color : 8'h00)) begin
          n_err++;
          $display("FAIL %s pixel h=%0d: got valid=%0b color=%0h, expected valid=%0b color=%0h",
                   name, h - 1, pix_valid, pix_color, prev_hit, prev_hit ? prev_color : 8'h00);
        end
      end
      prev_hit   = hit;
      prev_color = {3'b000, col};
      have_prev  = 1'b1;
    end
    video_on = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [2:0] exp);
    n_vec++;
    if (anim_frame !== exp) begin
      n_err++;
      $display("FAIL %s: got anim_frame=%0d, expected %0d", name, anim_frame, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (rom_addr !== 14'h0 || pix_valid !== 1'b0 || pix_color !== 8'h00 || anim_frame !== 3'd0) begin
      n_err++;
      $display("FAIL reset: got addr=%0h valid=%0b color=%0h frame=%0d, expected all 0",
               rom_addr, pix_valid, pix_color, anim_frame);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_frame_latch();
    pulse_frame(10'd100, 10'd200, 1'b1, 1'b0, 1'b0);
    scan("latch_right", 99, 133, 200, 100, 200, 1'b1, 3'd0);
    scan("latch_row7", 98, 102, 207, 100, 200, 1'b1, 3'd0);
  endtask

  task automatic test_mirror();
    pulse_frame(10'd100, 10'd200, 1'b0, 1'b0, 1'b0);
    check_frame("mirror_frame", 3'd0);
    scan("mirror", 99, 133, 200, 100, 200, 1'b0, 3'd0);
  endtask

  task automatic test_anim();
    for (int i = 1; i <= 30; i++) begin
      pulse_frame(10'd100, 10'd200, 1'b1, 1'b1, 1'b0);
      check_frame($sformatf("walk_%0d", i), 3'(((i - 1) / 6) % 4));
    end
    pulse_frame(10'd100, 10'd200, 1'b1, 1'b1, 1'b1);
    check_frame("jump_enter", 3'd4);
    pulse_frame(10'd100, 10'd200, 1'b1, 1'b0, 1'b1);
    check_frame("jump_hold", 3'd4);
    pulse_frame(10'd100, 10'd200, 1'b1, 1'b1, 1'b0);
    check_frame("jump_to_walk", 3'd0);
    for (int k = 1; k <= 6; k++) begin
      pulse_frame(10'd100, 10'd200, 1'b1, 1'b1, 1'b0);
      check_frame($sformatf("rewalk_%0d", k), (k == 6) ? 3'd1 : 3'd0);
    end
    pulse_frame(10'd100, 10'd200, 1'b1, 1'b0, 1'b0);
    check_frame("walk_to_idle", 3'd0);
  endtask

  task automatic test_key_color();
    pulse_frame(10'd100, 10'd200, 1'b1, 1'b0, 1'b0);
    rom_force = 1'b1;
    rom_force_val = 8'hE3;
    point("key_color", 110, 200, 1'b1, 1'b0, 8'h00);
    rom_force_val = 8'h1C;
    point("opaque_1c", 110, 200, 1'b1, 1'b1, 8'h1C);
    rom_force = 1'b0;
  endtask

  task automatic test_mid_frame_move();
    pulse_frame(10'd100, 10'd200, 1'b1, 1'b0, 1'b0);
    pos_x = 10'd300;
    point("old_pos_hit", 105, 200, 1'b1, 1'b1, 8'h05);
    point("new_pos_early", 305, 200, 1'b1, 1'b0, 8'h00);
    pulse_frame(10'd300, 10'd200, 1'b1, 1'b0, 1'b0);
    point("new_pos_hit", 305, 200, 1'b1, 1'b1, 8'h05);
    point("old_pos_gone", 105, 200, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_wrap_clip();
    pulse_frame(10'd1020, 10'd200, 1'b1, 1'b0, 1'b0);
    scan("wrap_low", 0, 10, 200, 1020, 200, 1'b1, 3'd0);
    scan("wrap_edge", 1017, 1023, 200, 1020, 200, 1'b1, 3'd0);
    point("video_off_clip", 1021, 200, 1'b0, 1'b0, 8'h00);
    point("row_above", 1021, 199, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_pix_en_hold();
    pulse_frame(10'd100, 10'd200, 1'b1, 1'b0, 1'b0);
    point("hold_setup", 110, 200, 1'b1, 1'b1, 8'h0A);
    pix_en = 1'b0;
    hcount = 10'd50;
    repeat (3) tick();
    n_vec++;
    if (pix_valid !== 1'b1 || pix_color !== 8'h0A || rom_addr !== {3'd0, 6'd0, 5'd10}) begin
      n_err++;
      $display("FAIL pix_en_hold: got valid=%0b color=%0h addr=%0h, expected 1/0a/%0h",
               pix_valid, pix_color, rom_addr, {3'd0, 6'd0, 5'd10});
    end
    pulse_frame(10'd100, 10'd200, 1'b1, 1'b0, 1'b1);
    check_frame("frame_start_no_pix_en", 3'd4);
    pix_en = 1'b1;
  endtask

  task automatic test_reset_mid_sprite();
    point("pre_reset_hit", 115, 205, 1'b1, 1'b1, 8'h0F);
    n_vec++;
    if (rom_addr !== {3'd4, 6'd5, 5'd15}) begin
      n_err++;
      $display("FAIL pre_reset_addr: got %0h, expected %0h", rom_addr, {3'd4, 6'd5, 5'd15});
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (rom_addr !== 14'h0 || pix_valid !== 1'b0 || pix_color !== 8'h00 || anim_frame !== 3'd0) begin
      n_err++;
      $display("FAIL reset_mid: got addr=%0h valid=%0b color=%0h frame=%0d, expected all 0",
               rom_addr, pix_valid, pix_color, anim_frame);
    end
    tick();
    reset = 1'b0;
    point("shadow_reset_origin", 3, 4, 1'b1, 1'b1, 8'h03);
    n_vec++;
    if (rom_addr !== {3'd0, 6'd4, 5'd3}) begin
      n_err++;
      $display("FAIL shadow_reset_addr: got %0h, expected %0h", rom_addr, {3'd0, 6'd4, 5'd3});
    end
  endtask

  initial begin
    test_reset();
    test_frame_latch();
    test_mirror();
    test_anim();
    test_key_color();
    test_mid_frame_move();
    test_wrap_clip();
    test_pix_en_hold();
    test_reset_mid_sprite();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
